// File: rtl/run_ctrl_seq_pkg.sv
// Shared types and helpers for the run-control sequencer.
package run_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_HOLD,
    S_RUN,
    S_DRAIN,
    S_PASS,
    S_ERR,
    S_TMO
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_PASS = 2'b01,
    ST_ERR  = 2'b10,
    ST_TMO  = 2'b11
  } status_e;

  // Width of a down-counter able to hold n (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/run_ctrl_seq_if.sv
// Core-facing run-control signals: core flags in, reset/status out.
interface run_ctrl_seq_if #(
  parameter int unsigned CNT_W = 32
);
  logic             err;
  logic             halt;
  logic             core_rst;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  err, halt,
    output core_rst, running, done, status, cycle_count
  );

  modport slave (
    output err, halt,
    input  core_rst, running, done, status, cycle_count
  );
endinterface

// File: rtl/run_ctrl_seq_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module run_ctrl_seq_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/run_ctrl_seq.sv
// Run-control sequencer: stretches reset into core reset, counts run cycles,
// and latches a terminal pass/error/timeout status until the next reset.
module run_ctrl_seq
  import run_ctrl_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned MAX_CYCLES   = 100004,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  run_ctrl_seq_if.master bus
);
  localparam int unsigned DW =
    cnt_w((RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] cnt;

  // HOLD and DRAIN are never active together, so they share one down-counter.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_RST: begin
        if (RST_CYCLES == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
          dcnt_d  = DW'(RST_CYCLES);
        end
      end
      S_HOLD: begin
        if (dcnt_q <= DW'(1)) state_d = S_RUN;
        else                  dcnt_d  = dcnt_q - DW'(1);
      end
      S_RUN: begin
        if (bus.err) begin
          state_d = S_ERR;
        end else if (bus.halt) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_PASS;
          end else begin
            state_d = S_DRAIN;
            dcnt_d  = DW'(DRAIN_CYCLES);
          end
        end else if (cnt == MAX_M1) begin
          state_d = S_TMO;
        end
      end
      S_DRAIN: begin
        if (bus.err)                 state_d = S_ERR;
        else if (dcnt_q <= DW'(1))   state_d = S_PASS;
        else                         dcnt_d  = dcnt_q - DW'(1);
      end
      default: ;
    endcase
    if (rst_i) begin
      state_d = S_RST;
      dcnt_d  = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    running_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    core_rst_d = !running_d;
    done_d     = (state_d == S_PASS) || (state_d == S_ERR) || (state_d == S_TMO);
    case (state_d)
      S_PASS:  status_d = ST_PASS;
      S_ERR:   status_d = ST_ERR;
      S_TMO:   status_d = ST_TMO;
      default: status_d = ST_NONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    state_q    <= state_d;
    dcnt_q     <= dcnt_d;
    core_rst_q <= core_rst_d;
    running_q  <= running_d;
    done_q     <= done_d;
    status_q   <= status_d;
  end

  run_ctrl_seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .en_i  ((state_q == S_RUN) || (state_q == S_DRAIN)),
    .cnt_o (cnt)
  );

  assign bus.core_rst    = core_rst_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.cycle_count = cnt;
endmodule

// File: tb/tb_run_ctrl_seq.sv
// Bench for run_ctrl_seq: three parameterisations share stimulus and are
// checked every cycle against an event-level model plus directed literals.
module tb_run_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err = 1'b0;
  logic halt = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  run_ctrl_seq_if #(.CNT_W(32)) ifa ();
  run_ctrl_seq_if #(.CNT_W(32)) ifb ();
  run_ctrl_seq_if #(.CNT_W(32)) ifc ();

  assign ifa.err = err;  assign ifa.halt = halt;
  assign ifb.err = err;  assign ifb.halt = halt;
  assign ifc.err = err;  assign ifc.halt = halt;

  run_ctrl_seq #(.RST_CYCLES(2), .MAX_CYCLES(100004), .DRAIN_CYCLES(4), .CNT_W(32))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  run_ctrl_seq #(.RST_CYCLES(2), .MAX_CYCLES(20), .DRAIN_CYCLES(4), .CNT_W(32))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  run_ctrl_seq #(.RST_CYCLES(0), .MAX_CYCLES(100004), .DRAIN_CYCLES(0), .CNT_W(32))
    dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  int     PR [3] = '{2, 2, 0};
  int     PD [3] = '{4, 4, 0};
  longint PM [3] = '{100004, 20, 100004};

  // Model: rel = edges since reset released, cnt = run cycles,
  // pass_at = count value at which draining ends, stat = terminal code.
  int     rel     [3];
  longint cnt     [3];
  longint pass_at [3];
  int     stat    [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      longint c;
      if (rst) begin
        rel[i] = 0; cnt[i] = 0; pass_at[i] = -1; stat[i] = 0;
      end else if (stat[i] == 0) begin
        if (rel[i] > PR[i]) begin
          c = cnt[i];
          cnt[i] = (c == 64'hFFFF_FFFF) ? c : c + 1;
          if (err) stat[i] = 2;
          else if (pass_at[i] < 0 && halt) begin
            pass_at[i] = c + 1 + PD[i];
            if (cnt[i] >= pass_at[i]) stat[i] = 1;
          end
          else if (pass_at[i] < 0 && c == PM[i] - 1) stat[i] = 3;
          else if (pass_at[i] >= 0 && cnt[i] >= pass_at[i]) stat[i] = 1;
        end
        if (rel[i] < 1000000) rel[i]++;
      end
    end
  end

  logic       a_core [3], a_run [3], a_done [3];
  logic [1:0] a_st   [3];
  logic [31:0] a_cnt [3];
  assign a_core[0] = ifa.core_rst; assign a_run[0] = ifa.running; assign a_done[0] = ifa.done;
  assign a_st[0] = ifa.status;     assign a_cnt[0] = ifa.cycle_count;
  assign a_core[1] = ifb.core_rst; assign a_run[1] = ifb.running; assign a_done[1] = ifb.done;
  assign a_st[1] = ifb.status;     assign a_cnt[1] = ifb.cycle_count;
  assign a_core[2] = ifc.core_rst; assign a_run[2] = ifc.running; assign a_done[2] = ifc.done;
  assign a_st[2] = ifc.status;     assign a_cnt[2] = ifc.cycle_count;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic e_run, e_done;
        e_run  = (stat[i] == 0) && (rel[i] > PR[i]);
        e_done = (stat[i] != 0);
        checks++;
        if (a_run[i] !== e_run || a_core[i] !== !e_run || a_done[i] !== e_done ||
            a_st[i] !== 2'(stat[i]) || longint'(a_cnt[i]) != cnt[i]) begin
          fails++;
          $display("FAIL model_dut%0d t=%0t: got core_rst=%b running=%b done=%b status=%0d count=%0d, expected core_rst=%b running=%b done=%b status=%0d count=%0d",
                   i, $time, a_core[i], a_run[i], a_done[i], a_st[i], a_cnt[i],
                   !e_run, e_run, e_done, stat[i], cnt[i]);
        end
      end
    end
  end

  task automatic lit(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_a(input longint target);
    int k = 0;
    while (longint'(ifa.cycle_count) != target && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      fails++;
      $display("FAIL wait_a: count stuck at %0d, expected to reach %0d", ifa.cycle_count, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; err = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    lit("reset_core_rst", ifa.core_rst, 1);
    lit("reset_running", ifa.running, 0);
    lit("reset_done", ifa.done, 0);
    lit("reset_status", ifa.status, 0);
    lit("reset_count", ifa.cycle_count, 0);

    // Reset release with RST_CYCLES=2 (A) and 0 (C)
    rst = 1'b0;
    @(negedge clk);
    lit("rel_e1_core_rst", ifa.core_rst, 1);
    lit("rel_e1_count", ifa.cycle_count, 0);
    lit("zero_e1_running", ifc.running, 1);
    @(negedge clk);
    lit("rel_e2_core_rst", ifa.core_rst, 1);
    @(negedge clk);
    lit("rel_e3_core_rst", ifa.core_rst, 0);
    lit("rel_e3_count", ifa.cycle_count, 0);

    // Normal halt at count 10 with 4 drain cycles
    wait_a(10);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (3) @(negedge clk);
    lit("drain_running", ifa.running, 1);
    lit("drain_count", ifa.cycle_count, 14);
    @(negedge clk);
    lit("pass_done", ifa.done, 1);
    lit("pass_status", ifa.status, 1);
    lit("pass_count", ifa.cycle_count, 15);
    repeat (5) @(negedge clk);
    lit("pass_frozen", ifa.cycle_count, 15);

    // err and halt together in RUN
    do_reset();
    wait_a(5);
    err = 1'b1; halt = 1'b1;
    @(negedge clk);
    err = 1'b0; halt = 1'b0;
    lit("errhalt_status", ifa.status, 2);
    lit("errhalt_running", ifa.running, 0);
    lit("errhalt_count", ifa.cycle_count, 6);

    // err during DRAIN
    do_reset();
    wait_a(5);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0; err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    lit("drainerr_status", ifa.status, 2);
    lit("drainerr_count", ifa.cycle_count, 7);

    // Mid-run reset then a clean re-run
    do_reset();
    wait_a(7);
    rst = 1'b1;
    @(negedge clk);
    lit("midrst_core_rst", ifa.core_rst, 1);
    lit("midrst_count", ifa.cycle_count, 0);
    lit("midrst_done", ifa.done, 0);
    rst = 1'b0;
    wait_a(3);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (4) @(negedge clk);
    lit("rerun_status", ifa.status, 1);
    lit("rerun_count", ifa.cycle_count, 8);

    // Timeout with MAX_CYCLES=20 (B); later halt must not change it
    do_reset();
    repeat (30) @(negedge clk);
    lit("tmo_done", ifb.done, 1);
    lit("tmo_status", ifb.status, 3);
    lit("tmo_count", ifb.cycle_count, 20);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (2) @(negedge clk);
    lit("tmo_sticky_status", ifb.status, 3);
    lit("tmo_sticky_count", ifb.cycle_count, 20);

    // Zero RST/DRAIN cycles (C)
    do_reset();
    @(negedge clk);
    lit("zero_running", ifc.running, 1);
    lit("zero_core_rst", ifc.core_rst, 0);
    repeat (3) @(negedge clk);
    lit("zero_count", ifc.cycle_count, 3);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    lit("zero_pass_status", ifc.status, 1);
    lit("zero_pass_count", ifc.cycle_count, 4);

    // Random traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(0, 63) == 0);
      err  = ($urandom_range(0, 39) == 0);
      halt = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
